ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
- Receive-only PS/2 host interface: takes the keyboard's open-collector PS2_CLK/PS2_DAT lines and delivers each validated scan-code byte with a one-cycle strobe on the 50 MHz system clock.
- Sits between the board PS/2 pins and the scan-code parser that feeds the keyboard buffers.
- The host never drives the bus: no inhibit, no command transmission.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per PS/2 line.
- FILTER_LEN, 8: consecutive equal samples required before a filtered line changes value.
- TIMEOUT_CYCLES, 10000: maximum system cycles between filtered clock falling edges inside a frame (200 us at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- received_data  output  8  last valid byte received.
- received_data_en  output  1  one-cycle strobe: received_data was just updated.
- frame_error  output  1  one-cycle strobe: frame discarded (parity, stop bit or timeout).
- PS2_CLK  inout  1  PS/2 clock line; always driven 1'bz.
- PS2_DAT  inout  1  PS/2 data line; always driven 1'bz.

Behaviour:
- Reset (reset=0, asynchronous):
  - received_data=0x00, received_data_en=0, frame_error=0.
  - FSM in IDLE; bit counter, shift register and timeout counter cleared.
  - Synchronizer and filter state set to 1 (idle-high bus).
- Reset asserted mid-frame: the partial frame is abandoned with no strobe.
- Line conditioning, identical path for both lines:
  - SYNC_STAGES-flop synchronizer.
  - Glitch filter: the output takes the new level only after FILTER_LEN consecutive identical synchronized samples. Shorter pulses are ignored.
- Edge detect: a registered copy of the filtered clock. fall = prev & ~cur, high for exactly one cycle.
- Data is sampled from the filtered data line in the same cycle fall is high.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit) go to DATA with bitcnt=0. On fall with data=1, stay in IDLE with no strobe.
  - DATA: on each fall, shift = {data, shift[7:1]} (LSB first) and increment bitcnt. After the 8th bit go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, the frame is good if data==1 and (^shift ^ parity)==1 (odd parity).
    - Good frame: received_data<=shift, received_data_en=1 for one cycle.
    - Otherwise: frame_error=1 for one cycle and received_data unchanged.
    - Go to IDLE in either case.
- Timeout:
  - In DATA, PARITY or STOP, the counter counts cycles since the last fall and is cleared on every fall.
  - On reaching TIMEOUT_CYCLES: frame_error=1 for one cycle, go to IDLE, discard the partial byte.
  - The counter is held at 0 in IDLE.
- Latency: from the raw pin falling edge of the stop bit to received_data_en high is SYNC_STAGES+FILTER_LEN+1 cycles (11 at defaults), with received_data valid in the same cycle.
- received_data holds its value between strobes.
- received_data_en and frame_error are never high in the same cycle.
- The block performs no scan-code interpretation: E0/F0 prefixes are delivered as ordinary bytes.
- Back-to-back frames need no idle gap beyond the stop bit.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE/DATA/PARITY/STOP).
  - Constants: PS2_DATA_BITS=8, PS2_FRAME_BITS=11, default TIMEOUT_CYCLES.
- Sub-module ps2_line_filter (synchronizer plus glitch filter, parameterised by SYNC_STAGES and FILTER_LEN), instantiated once per line.
- FSM, shift register and timeout counter live in ps2_receiver.

Test Plan:
- Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; 100-cycle half periods) -> one received_data_en pulse with received_data=0x1C, frame_error stays 0.
- Sequence 0xF0 (parity 1) then 0x1C back-to-back -> two strobes, data 0xF0 then 0x1C, each exactly one cycle wide.
- Frame 0x1C with parity bit forced to 1 -> frame_error pulse, no received_data_en, received_data keeps its previous value.
- Three-cycle low glitch on PS2_CLK while idle, and a data-line glitch shorter than FILTER_LEN mid-bit -> no state change; a subsequent frame 0x5A (parity 1) is received correctly.
- Frame stopped after 5 data bits, clock held high for more than 10000 cycles -> frame_error pulse at timeout; a following 0x5A frame yields received_data=0x5A.
- reset pulsed low after the 4th data bit of a frame -> outputs read 0 immediately, no strobe for that frame; the next full 0x1C frame is received.
- All tests: PS2_CLK and PS2_DAT are never driven by the DUT (always Z).

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared states and constants for the PS/2 receive path. Rev 1.0
// ============================================================================
package ps2_pkg;

  localparam int PS2_DATA_BITS      = 8;
  localparam int PS2_FRAME_BITS     = 11;
  localparam int PS2_TIMEOUT_CYCLES = 10000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Stop bit high and odd parity over data plus parity bit.
  function automatic logic ps2_frame_ok(input logic [PS2_DATA_BITS-1:0] data,
                                        input logic parity,
                                        input logic stop);
    return stop & ((^data) ^ parity);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// ps2_line_filter : synchronizer plus run-length glitch filter. Rev 1.0
// ============================================================================
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   line_q, line_d;
  logic                   w_sync;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_comb sync_d = i_line;
    end else begin : g_sync_chain
      always_comb sync_d = {sync_q[SYNC_STAGES-2:0], i_line};
    end
  endgenerate

  assign w_sync = sync_q[SYNC_STAGES-1];

  // cnt_q counts consecutive samples that disagree with the current output.
  always_comb begin
    cnt_d  = '0;
    line_d = line_q;
    if (w_sync != line_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        line_d = w_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      line_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign o_line = line_q;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// ps2_receiver : receive-only PS/2 host, one strobe per validated byte. Rev 1.0
// ============================================================================
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(PS2_DATA_BITS);

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = reset;

  // The host only listens; both lines are left to the keyboard's pull-ups.
  assign PS2_CLK = 1'bz;
  assign PS2_DAT = 1'bz;

  logic w_clk_f, w_dat_f, w_fall;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (PS2_CLK),
    .o_line (w_clk_f)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (PS2_DAT),
    .o_line (w_dat_f)
  );

  ps2_state_e                 state_q, state_d;
  logic [BIT_W-1:0]           bitcnt_q, bitcnt_d;
  logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
  logic                       parity_q, parity_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0]   data_q, data_d;
  logic                       en_q, en_d;
  logic                       err_q, err_d;
  logic                       clk_prev_q;

  assign w_fall = clk_prev_q & ~w_clk_f;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    en_d     = 1'b0;
    err_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      tmo_d = '0;
      if (w_fall && !w_dat_f) begin
        state_d  = ST_DATA;
        bitcnt_d = '0;
        shift_d  = '0;
      end
    end else if (w_fall) begin
      tmo_d = '0;
      case (state_q)
        ST_DATA: begin
          shift_d  = {w_dat_f, shift_q[PS2_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = w_dat_f;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (ps2_frame_ok(shift_q, parity_q, w_dat_f)) begin
            data_d = shift_q;
            en_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      // Keyboard stalled mid-frame: drop the partial byte and resync on the next start bit.
      err_d    = 1'b1;
      state_d  = ST_IDLE;
      tmo_d    = '0;
      bitcnt_d = '0;
      shift_d  = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      en_q       <= en_d;
      err_q      <= err_d;
      clk_prev_q <= w_clk_f;
    end
  end

  assign received_data    = data_q;
  assign received_data_en = en_q;
  assign frame_error      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// tb_ps2_receiver : directed frames against ps2_receiver. Rev 1.0
// ============================================================================
module tb_ps2_receiver;

  logic       clk;
  logic       reset;
  logic       kb_clk;
  logic       kb_dat;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;
  wire        ps2_clk;
  wire        ps2_dat;

  assign ps2_clk = kb_clk;
  assign ps2_dat = kb_dat;

  ps2_receiver dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .frame_error      (frame_error),
    .PS2_CLK          (ps2_clk),
    .PS2_DAT          (ps2_dat)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int en_cnt   = 0;
  int err_cnt  = 0;
  int wide_cnt = 0;
  int both_cnt = 0;
  logic [7:0] rx_q[$];
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    if (received_data_en) begin
      en_cnt++;
      rx_q.push_back(received_data);
      if (en_prev) wide_cnt++;
    end
    if (frame_error) err_cnt++;
    if (received_data_en && frame_error) both_cnt++;
    en_prev = received_data_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data changes mid-high, clock low 100 cycles then high.
  task automatic send_bit(input logic b, input logic glitch);
    wait_cyc(50);
    kb_dat = b;
    wait_cyc(50);
    kb_clk = 1'b0;
    if (glitch) begin
      wait_cyc(40);
      kb_dat = ~b;
      wait_cyc(3);
      kb_dat = b;
      wait_cyc(57);
    end else begin
      wait_cyc(100);
    end
    kb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input int glitch_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i);
    send_bit(par, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int en0, err0;

  initial begin
    reset  = 1'b0;
    kb_clk = 1'b1;
    kb_dat = 1'b1;
    wait_cyc(5);
    chk("rst_data", {24'h0, received_data}, 32'h00);
    chk("rst_en",   {31'h0, received_data_en}, 32'h0);
    chk("rst_err",  {31'h0, frame_error}, 32'h0);
    reset = 1'b1;
    wait_cyc(20);
    chk("bus_clk_idle", {31'h0, ps2_clk}, 32'h1);

    // Single good frame 0x1C
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h1C, 1'b0, -1);
    wait_cyc(50);
    chk("f1c_en_cnt", en_cnt - en0, 1);
    chk("f1c_data",   {24'h0, received_data}, 32'h1C);
    chk("f1c_err",    err_cnt - err0, 0);

    // Back-to-back 0xF0 then 0x1C
    rx_q.delete();
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'hF0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, -1);
    wait_cyc(50);
    chk("b2b_en_cnt", en_cnt - en0, 2);
    chk("b2b_first",  (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hFFFF, 32'hF0);
    chk("b2b_second", (rx_q.size() > 1) ? {24'h0, rx_q[1]} : 32'hFFFF, 32'h1C);
    chk("b2b_err",    err_cnt - err0, 0);

    // Bad parity on 0x1C
    en0 = en_cnt; err0 = err_cnt;
    send_frame(8'h1C, 1'b1, -1);
    wait_cyc(50);
    chk("par_err_cnt", err_cnt - err0, 1);
    chk("par_en_cnt",  en_cnt - en0, 0);
    chk("par_hold",    {24'h0, received_data}, 32'h1C);

    // Clock glitch while idle, then 0x5A with a data glitch mid-bit
    en0 = en_cnt; err0 = err_cnt;
    kb_clk = 1'b0;
    wait_cyc(3);
    kb_clk = 1'b1;
    wait_cyc(100);
    chk("glitch_idle_en",  en_cnt - en0, 0);
    chk("glitch_idle_err", err_cnt - err0, 0);
    send_frame(8'h5A, 1'b1, 3);
    wait_cyc(50);
    chk("glitch_en_cnt", en_cnt - en0, 1);
    chk("glitch_data",   {24'h0, received_data}, 32'h5A);
    chk("glitch_err",    err_cnt - err0, 0);

    // Stalled frame: start plus 5 data bits, then clock idle past the timeout
    en0 = en_cnt; err0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    kb_dat = 1'b1;
    wait_cyc(10300);
    chk("tmo_err_cnt", err_cnt - err0, 1);
    chk("tmo_en_cnt",  en_cnt - en0, 0);
    send_frame(8'h5A, 1'b1, -1);
    wait_cyc(50);
    chk("tmo_next_data", {24'h0, received_data}, 32'h5A);
    chk("tmo_next_en",   en_cnt - en0, 1);

    // Reset in the middle of a frame
    en0 = en_cnt; err0 = err_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_cyc(20);
    reset = 1'b0;
    #1;
    chk("midrst_data", {24'h0, received_data}, 32'h00);
    chk("midrst_en",   {31'h0, received_data_en}, 32'h0);
    chk("midrst_err",  {31'h0, frame_error}, 32'h0);
    kb_dat = 1'b1;
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(100);
    chk("midrst_no_strobe", en_cnt - en0, 0);
    send_frame(8'h1C, 1'b0, -1);
    wait_cyc(50);
    chk("midrst_next_data", {24'h0, received_data}, 32'h1C);
    chk("midrst_next_en",   en_cnt - en0, 1);
    chk("midrst_next_err",  err_cnt - err0, 0);

    chk("strobe_width", wide_cnt, 0);
    chk("en_err_overlap", both_cnt, 0);
    chk("bus_clk_end", {31'h0, ps2_clk}, {31'h0, kb_clk});
    chk("bus_dat_end", {31'h0, ps2_dat}, {31'h0, kb_dat});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
